// File: rtl/key_expansion.sv
// AES-128 key expansion. Emits the 11 round keys in order, one per valid/ready handshake,
// and pulses done once the last key has been taken.
module key_expansion (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key,
    input  logic         rk_ready,
    output logic         rk_valid,
    output logic [127:0] round_key,
    output logic [3:0]   rk_round,
    output logic         busy,
    output logic         done
);
    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e       state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   round_q, round_d;
    logic         done_q, done_d;

    logic [31:0]  w0, w1, w2, w3, t, n0, n1, n2, n3;
    logic [7:0]   rcon;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        // a^254 is the multiplicative inverse in GF(2^8); 0 maps to 0 as required
        sq  = gf_mul(a, a);
        inv = sq;
        for (int i = 0; i < 6; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    always_comb begin
        case (round_q)
            4'd0:    rcon = 8'h01;
            4'd1:    rcon = 8'h02;
            4'd2:    rcon = 8'h04;
            4'd3:    rcon = 8'h08;
            4'd4:    rcon = 8'h10;
            4'd5:    rcon = 8'h20;
            4'd6:    rcon = 8'h40;
            4'd7:    rcon = 8'h80;
            4'd8:    rcon = 8'h1b;
            4'd9:    rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign w0 = key_q[127:96];
    assign w1 = key_q[95:64];
    assign w2 = key_q[63:32];
    assign w3 = key_q[31:0];
    assign t  = sub_word({w3[23:0], w3[31:24]}) ^ {rcon, 24'h000000};
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    key_d   = key;
                    round_d = 4'd0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (rk_ready) begin
                    if (round_q == 4'd10) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        key_d   = {n0, n1, n2, n3};
                        round_d = round_q + 4'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            key_q   <= '0;
            round_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
            done_q  <= done_d;
        end
    end

    assign rk_valid  = (state_q == StRun);
    assign busy      = (state_q == StRun);
    assign round_key = key_q;
    assign rk_round  = round_q;
    assign done      = done_q;
endmodule

// File: tb/tb_key_expansion.sv
// Self-checking bench for key_expansion: known-answer table, random keys with random
// back-pressure against a word-recurrence model, plus start/reset corner sequences.
module tb_key_expansion;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] key;
    logic         rk_ready;
    logic         rk_valid;
    logic [127:0] round_key;
    logic [3:0]   rk_round;
    logic         busy;
    logic         done;

    key_expansion dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .key       (key),
        .rk_ready  (rk_ready),
        .rk_valid  (rk_valid),
        .round_key (round_key),
        .rk_round  (rk_round),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] k;
        int           round;
        logic [127:0] exp;
    } kat_t;

    int           n_cmp = 0;
    int           n_fail = 0;
    logic [7:0]   tb_sbox [256];
    logic [127:0] exp_rk [11];
    logic [127:0] got [11];
    kat_t         kat [6];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8]
                     ^ inv[(i + 7) % 8] ^ c[i];
            tb_sbox[x] = s;
        end
    endtask

    task automatic model(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {tb_sbox[t[31:24]], tb_sbox[t[23:16]], tb_sbox[t[15:8]], tb_sbox[t[7:0]]}
                  ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r < 11; r++) exp_rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    task automatic kick(input logic [127:0] k);
        @(negedge clk);
        start = 1'b1;
        key   = k;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Entered on the first negedge after the start edge; follows one whole expansion.
    task automatic collect(input logic [127:0] k, input bit rnd, input bit inject,
                           input bit chain, input logic [127:0] ck);
        int hs, dn, c, done_at;
        bit fin, injected;
        hs = 0; dn = 0; c = 1; done_at = 0; fin = 0; injected = 0;
        for (int r = 0; r < 11; r++) got[r] = '0;
        model(k);
        while (!fin && c <= 200) begin
            if (done) begin
                dn++;
                if (done_at == 0) begin
                    done_at = c;
                    chk("done ctl", 128'({rk_valid, busy}), 128'(2'b00));
                    chk("done key hold", round_key, exp_rk[10]);
                    chk("done round hold", 128'(rk_round), 128'(10));
                end
                if (chain) begin
                    start = 1'b1;
                    key   = ck;
                    fin   = 1;
                end
            end else if (done_at == 0 && hs < 11) begin
                chk("valid busy", 128'({rk_valid, busy}), 128'(2'b11));
                chk("round key", round_key, exp_rk[hs]);
                chk("round idx", 128'(rk_round), 128'(hs));
            end
            if (!chain && done_at != 0 && c >= done_at + 3) fin = 1;
            if (!fin) begin
                start = 1'b0;
                if (inject && !injected && rk_valid && rk_round == 4'd5) begin
                    start    = 1'b1;
                    key      = ~k;
                    injected = 1;
                end
                rk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (rk_valid && rk_ready) begin
                    if (rk_round < 4'd11) got[rk_round] = round_key;
                    hs++;
                end
                @(negedge clk);
                c++;
            end
        end
        if (done_at == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL timeout: got no done after %0d cycles, required done", c);
        end
        chk("handshakes", 128'(hs), 128'(11));
        chk("done pulses", 128'(dn), 128'(1));
        if (!rnd) chk("latency", 128'(done_at), 128'(12));
    endtask

    initial begin
        logic [127:0] ka, kb;
        rst_n = 1'b0; start = 1'b0; key = '0; rk_ready = 1'b0;
        build_sbox();

        kat[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 1, 128'ha0fafe1788542cb123a339392a6c7605};
        kat[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 2, 128'hf2c295f27a96b9435935807a7359f67f};
        kat[2] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        kat[3] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 0, 128'h2b7e151628aed2a6abf7158809cf4f3c};
        kat[4] = '{128'h0, 0, 128'h0};
        kat[5] = '{128'h0, 1, 128'h62636363626363636263636362636363};

        repeat (2) @(negedge clk);
        chk("reset key", round_key, '0);
        chk("reset ctl", 128'({rk_valid, busy, done, rk_round}), 128'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle ctl", 128'({rk_valid, busy, done}), 128'(0));

        for (int i = 0; i < 6; i++) begin
            kick(kat[i].k);
            collect(kat[i].k, 0, 0, 0, '0);
            chk($sformatf("kat%0d r%0d", i, kat[i].round), got[kat[i].round], kat[i].exp);
        end

        // FIPS key under random back-pressure, with a foreign start at round 5
        ka = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        kick(ka);
        collect(ka, 1, 1, 0, '0);
        chk("bp r10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        for (int i = 0; i < 4; i++) begin
            ka = {$urandom, $urandom, $urandom, $urandom};
            kick(ka);
            collect(ka, 1, (i == 0), 0, '0);
        end

        // start in the done cycle starts a fresh expansion
        ka = {$urandom, $urandom, $urandom, $urandom};
        kb = {$urandom, $urandom, $urandom, $urandom};
        kick(ka);
        collect(ka, 0, 0, 1, kb);
        @(negedge clk);
        start = 1'b0;
        collect(kb, 1, 0, 0, '0);

        // asynchronous reset mid-run, then a clean restart
        kick(ka);
        rk_ready = 1'b1;
        for (int i = 0; i < 20 && rk_round != 4'd6; i++) @(negedge clk);
        chk("reach r6", 128'(rk_round), 128'(6));
        #2 rst_n = 1'b0;
        #1;
        chk("async rst key", round_key, '0);
        chk("async rst ctl", 128'({rk_valid, busy, done, rk_round}), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        kick(kb);
        collect(kb, 0, 0, 0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/key_expansion.md
KEY_EXPANSION -- requirements
Module: key_expansion

Interface
REQ-001 Parameters SHALL be: none; the block is fixed to AES-128 (4-word key, 11 round keys).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request to expand key; sampled only in IDLE.
REQ-005 key  input  128  cipher key; key[127:96]=w0 … key[31:0]=w3, byte 0 at key[127:120] (FIPS-197 order).
REQ-006 rk_ready  input  1  consumer (round datapath) ready for a round key.
REQ-007 rk_valid  output  1  round_key/rk_round valid.
REQ-008 round_key  output  128  current round key, same word/byte order as key.
REQ-009 rk_round  output  4  index 0..10 of round_key.
REQ-010 busy  output  1  high while not IDLE.
REQ-011 done  output  1  one-cycle pulse after round key 10 is accepted.

Function
REQ-012 FSM SHALL have two states: IDLE and RUN.
REQ-013 IDLE with start=1 at edge t: latch key into round_key, rk_round=0, rk_valid=1, busy=1, state RUN, visible after edge t.
REQ-014 Start in RUN SHALL be ignored; key input SHALL not be re-sampled while busy.
REQ-015 Handshake occurs on an edge where rk_valid=1 and rk_ready=1; with rk_ready=0, round_key, rk_round, rk_valid SHALL hold unchanged.
REQ-016 Handshake with rk_round=r<10: next round_key = expansion of current, rk_round=r+1, rk_valid stays 1 (one key per cycle at full throughput).
REQ-017 Expansion: t = SubWord(RotWord(w3)) XOR {Rcon[r+1],00,00,00}; w0'=w0^t; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
REQ-018 RotWord: [a0,a1,a2,a3]->[a1,a2,a3,a0]; SubWord applies AES S-box per byte (table or GF(2^8) inverse plus affine, must match FIPS-197 exactly).
REQ-019 Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36 hex, selected from rk_round; no modular wrap beyond 10.
REQ-020 Handshake with rk_round=10: state IDLE, rk_valid=0, busy=0, done=1 for exactly the next cycle; round_key and rk_round hold last values.
REQ-021 start=1 in the cycle done=1 (state IDLE) SHALL be accepted per REQ-013.
REQ-022 rk_round SHALL never exceed 10; rk_valid SHALL be 0 in IDLE.
REQ-023 Latency: key 0 valid 1 cycle after start; key 10 valid 11 cycles after start with rk_ready held high; total 12 cycles to done.

Reset
REQ-024 rst_n=0 at any time, including mid-RUN, SHALL immediately force state IDLE, round_key=0, rk_round=0, rk_valid=0, busy=0, done=0.
REQ-025 After rst_n release, first start SHALL begin a fresh expansion from round 0; no residue from aborted run.

Verification
REQ-026 key=2b7e151628aed2a6abf7158809cf4f3c, start, rk_ready=1 -> round 1 a0fafe1788542cb123a339392a6c7605, round 10 d014f9a8c9ee2589e13f0cc8b6630ca6, done 12 cycles after start.
REQ-027 key=0 -> round 1 62636363626363636263636362636363, round 0 all-zero.
REQ-028 rk_ready toggled randomly during REQ-026 run -> identical key sequence, outputs stable while rk_ready=0, exactly 11 handshakes, one done pulse.
REQ-029 start pulsed with different key at round 5 -> ignored, sequence unchanged; start in done cycle -> new round 0 next cycle.
REQ-030 rst_n low at round 6 -> all outputs 0 asynchronously; restart yields correct full sequence from round 0.
